maxpool_stream: RTL and testbench

//  Downstream consumer of the convolution engine's y stream. Splits each frame of LEN signed

---
 rtl/maxpool_stream.sv | 110 +++++++++++
 tb/tb_maxpool_stream.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/maxpool_stream.sv
// Streaming 1-D max-pool: signed max over POOL-sample windows of a LEN-sample frame, results queued
// in a DEPTH-entry FIFO with a last-of-frame flag. Define MAXPOOL_RELU_EN to clamp pooled values at 0.
module maxpool_stream #(
    parameter int WIDTH = 16,
    parameter int LEN   = 5,
    parameter int POOL  = 2,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] s_data_in_y,
    input  logic             s_valid_y,
    output logic             s_ready_y,
    output logic [WIDTH-1:0] m_data_out_z,
    output logic             m_valid_z,
    input  logic             m_ready_z,
    output logic             m_last_z
);

    localparam int WCW = (POOL > 1) ? $clog2(POOL) : 1;
    localparam int FCW = (LEN > 1) ? $clog2(LEN) : 1;
    localparam int AW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW  = $clog2(DEPTH + 1);

    typedef struct packed {
        logic             last;
        logic [WIDTH-1:0] data;
    } entry_t;

    logic [WCW-1:0]          win_cnt;
    logic [FCW-1:0]          frame_cnt;
    logic signed [WIDTH-1:0] run_max;

    entry_t         mem [DEPTH];
    logic [AW-1:0]  wr_ptr;
    logic [AW-1:0]  rd_ptr;
    logic [CW-1:0]  count;

    logic                    accept;
    logic                    pop;
    logic                    frame_last;
    logic                    window_close;
    logic signed [WIDTH-1:0] sample;
    logic signed [WIDTH-1:0] win_max;
    logic signed [WIDTH-1:0] push_data;

    // Handshake outputs depend only on registered state (and reset), never on m_ready_z.
    assign s_ready_y    = reset && (count != CW'(DEPTH));
    assign m_valid_z    = reset && (count != '0);
    assign m_data_out_z = reset ? mem[rd_ptr].data : '0;
    assign m_last_z     = reset ? mem[rd_ptr].last : 1'b0;

    assign accept = s_valid_y && s_ready_y;
    assign pop    = m_valid_z && m_ready_z;

    always_comb begin
        // NOTE: every combinational output gets a default first so no path can infer a latch.
        sample       = $signed(s_data_in_y);
        frame_last   = (frame_cnt == FCW'(LEN - 1));
        window_close = accept && ((win_cnt == WCW'(POOL - 1)) || frame_last);
        win_max      = sample;
        if ((win_cnt != '0) && (run_max > sample)) begin
            win_max = run_max;
        end
`ifdef MAXPOOL_RELU_EN
        push_data = win_max[WIDTH-1] ? '0 : win_max;
`else
        push_data = win_max;
`endif
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            win_cnt   <= '0;
            frame_cnt <= '0;
            run_max   <= '0;
        end else if (accept) begin
            run_max   <= win_max;
            win_cnt   <= window_close ? '0 : win_cnt + WCW'(1);
            frame_cnt <= frame_last ? '0 : frame_cnt + FCW'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            // NOTE: the storage array is cleared too, so the head reads as zero after reset.
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (window_close) begin
                mem[wr_ptr] <= '{last: frame_last, data: push_data};
                wr_ptr      <= (wr_ptr == AW'(DEPTH - 1)) ? '0 : wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= (rd_ptr == AW'(DEPTH - 1)) ? '0 : rd_ptr + AW'(1);
            end
            case ({window_close, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_maxpool_stream.sv
// Self-checking bench for maxpool_stream: directed vector table, hand-written stall/reset
// sequences, and randomized traffic scored against a window/frame-level queue model.
module tb_maxpool_stream;

    localparam int WIDTH = 16;
    localparam int LEN   = 5;
    localparam int POOL  = 2;
    localparam int DEPTH = 4;

`ifdef MAXPOOL_RELU_EN
    localparam logic signed [WIDTH-1:0] NEG4   = 16'sd0;
    localparam logic signed [WIDTH-1:0] MOSTNEG = 16'sd0;
`else
    localparam logic signed [WIDTH-1:0] NEG4   = -16'sd4;
    localparam logic signed [WIDTH-1:0] MOSTNEG = 16'sh8000;
`endif

    logic             clk = 1'b0;
    logic             reset;
    logic [WIDTH-1:0] s_data_in_y;
    logic             s_valid_y;
    logic             s_ready_y;
    logic [WIDTH-1:0] m_data_out_z;
    logic             m_valid_z;
    logic             m_ready_z;
    logic             m_last_z;

    maxpool_stream #(.WIDTH(WIDTH), .LEN(LEN), .POOL(POOL), .DEPTH(DEPTH)) dut (
        .clk          (clk),
        .reset        (reset),
        .s_data_in_y  (s_data_in_y),
        .s_valid_y    (s_valid_y),
        .s_ready_y    (s_ready_y),
        .m_data_out_z (m_data_out_z),
        .m_valid_z    (m_valid_z),
        .m_ready_z    (m_ready_z),
        .m_last_z     (m_last_z)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic signed [WIDTH-1:0] data;
        logic                    last;
    } res_t;

    typedef struct {
        logic signed [WIDTH-1:0] din;
        logic                    has_out;
        logic signed [WIDTH-1:0] dout;
        logic                    last;
    } vec_t;

    res_t                    exp_q[$];
    res_t                    out_log[$];
    logic signed [WIDTH-1:0] win_q[$];
    int                      fidx;
    int                      max_depth;
    int                      checks;
    int                      errors;
    logic                    rand_ready;

    task automatic check(input string name, input logic signed [63:0] act, input logic signed [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic signed [WIDTH-1:0] relu(input logic signed [WIDTH-1:0] v);
`ifdef MAXPOOL_RELU_EN
        return (v < 0) ? '0 : v;
`else
        return v;
`endif
    endfunction

    // Reference: collect the window's samples, emit the max when the window or frame ends.
    task automatic model_accept(input logic signed [WIDTH-1:0] v);
        logic signed [WIDTH-1:0] m;
        res_t e;
        win_q.push_back(v);
        if (win_q.size() == POOL || fidx == LEN - 1) begin
            m = win_q[0];
            foreach (win_q[i]) if (win_q[i] > m) m = win_q[i];
            e.data = relu(m);
            e.last = (fidx == LEN - 1);
            exp_q.push_back(e);
            win_q.delete();
        end
        fidx = (fidx == LEN - 1) ? 0 : fidx + 1;
    endtask

    always @(negedge clk) begin
        res_t o;
        if (!reset) begin
            check("rst_s_ready", s_ready_y, 0);
            check("rst_m_valid", m_valid_z, 0);
            check("rst_m_data", m_data_out_z, 0);
            check("rst_m_last", m_last_z, 0);
            exp_q.delete();
            win_q.delete();
            out_log.delete();
            fidx = 0;
        end else begin
            check("sb_m_valid", m_valid_z, exp_q.size() != 0);
            check("sb_s_ready", s_ready_y, exp_q.size() != DEPTH);
            if (m_valid_z && exp_q.size() != 0) begin
                check("sb_data", $signed(m_data_out_z), exp_q[0].data);
                check("sb_last", m_last_z, exp_q[0].last);
            end
            if (m_valid_z && m_ready_z) begin
                o.data = $signed(m_data_out_z);
                o.last = m_last_z;
                out_log.push_back(o);
                if (exp_q.size() != 0) void'(exp_q.pop_front());
            end
            if (s_valid_y && s_ready_y) model_accept($signed(s_data_in_y));
            if (exp_q.size() > max_depth) max_depth = exp_q.size();
        end
    end

    always @(posedge clk) begin
        if (rand_ready) begin
            #1 m_ready_z = 1'($urandom_range(0, 1));
        end
    end

    task automatic sync();
        @(posedge clk);
        #1;
    endtask

    // Caller is at posedge+1; returns at posedge+1 right after the accepting edge.
    task automatic send(input logic signed [WIDTH-1:0] v);
        int n = 0;
        s_valid_y   = 1'b1;
        s_data_in_y = v;
        @(negedge clk);
        while (!s_ready_y && n < 200) begin
            n++;
            @(negedge clk);
        end
        if (!s_ready_y) check("send_timeout", 0, 1);
        @(posedge clk);
        #1;
        s_valid_y = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        @(negedge clk);
        while (m_valid_z && n < 100) begin
            n++;
            @(negedge clk);
        end
        check("drain_empty", m_valid_z, 0);
        sync();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl[10];
        logic signed [WIDTH-1:0] f3[10];
        logic signed [WIDTH-1:0] v;

        tbl[0] = '{16'sd3,      1'b0, 16'sd0,      1'b0};
        tbl[1] = '{-16'sd1,     1'b1, 16'sd3,      1'b0};
        tbl[2] = '{16'sd7,      1'b0, 16'sd0,      1'b0};
        tbl[3] = '{16'sd9,      1'b1, 16'sd9,      1'b0};
        tbl[4] = '{-16'sd4,     1'b1, NEG4,        1'b1};
        tbl[5] = '{16'sh8000,   1'b0, 16'sd0,      1'b0};
        tbl[6] = '{16'sh8000,   1'b1, MOSTNEG,     1'b0};
        tbl[7] = '{16'sd32767,  1'b0, 16'sd0,      1'b0};
        tbl[8] = '{16'sh8000,   1'b1, 16'sd32767,  1'b0};
        tbl[9] = '{16'sd0,      1'b1, 16'sd0,      1'b1};

        f3 = '{16'sd3, -16'sd1, 16'sd7, 16'sd9, -16'sd4, 16'sd5, 16'sd6, -16'sd7, -16'sd8, 16'sd2};

        checks = 0; errors = 0; fidx = 0; max_depth = 0; rand_ready = 1'b0;
        reset = 1'b0; s_valid_y = 1'b0; s_data_in_y = '0; m_ready_z = 1'b0;

        repeat (3) @(negedge clk);
        sync();
        reset = 1'b1;

        // Directed frames: basic pooling, then extreme values without overflow.
        m_ready_z = 1'b1;
        for (int i = 0; i < 10; i++) begin
            send(tbl[i].din);
            @(negedge clk);
            check($sformatf("tbl%0d_valid", i), m_valid_z, tbl[i].has_out);
            if (tbl[i].has_out) begin
                check($sformatf("tbl%0d_data", i), $signed(m_data_out_z), tbl[i].dout);
                check($sformatf("tbl%0d_last", i), m_last_z, tbl[i].last);
            end
            sync();
        end

        // Backpressure: the FIFO fills on sample 7 and the head holds until the consumer wakes up.
        m_ready_z = 1'b0;
        for (int i = 0; i < 7; i++) send(f3[i]);
        @(negedge clk);
        check("stall_s_ready", s_ready_y, 0);
        check("stall_m_valid", m_valid_z, 1);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("stall_head", $signed(m_data_out_z), 3);
            check("stall_blocked", s_ready_y, 0);
        end
        sync();
        m_ready_z = 1'b1;
        for (int i = 7; i < 10; i++) send(f3[i]);
        drain();

        // Reset mid-frame discards the partial window and the queued result.
        m_ready_z = 1'b0;
        send(16'sd3); send(-16'sd1); send(16'sd7);
        @(negedge clk);
        check("pre_rst_valid", m_valid_z, 1);
        sync();
        reset = 1'b0;
        #1;
        check("async_rst_valid", m_valid_z, 0);
        check("async_rst_ready", s_ready_y, 0);
        check("async_rst_data", m_data_out_z, 0);
        repeat (2) @(negedge clk);
        sync();
        reset = 1'b1;
        m_ready_z = 1'b1;
        out_log.delete();
        for (int i = 1; i <= 5; i++) send(16'(i));
        drain();
        check("post_rst_count", out_log.size(), 3);
        if (out_log.size() == 3) begin
            check("post_rst_r0", out_log[0].data, 2);
            check("post_rst_r1", out_log[1].data, 4);
            check("post_rst_r2", out_log[2].data, 5);
            check("post_rst_last0", out_log[0].last, 0);
            check("post_rst_last2", out_log[2].last, 1);
        end

        // Back-to-back random frames with a always-ready consumer.
        out_log.delete();
        max_depth = 0;
        for (int i = 0; i < 8 * LEN; i++) begin
            v = ($urandom_range(0, 7) == 0) ? 16'sh8000 : WIDTH'($urandom);
            send(v);
        end
        drain();
        check("b2b_max_depth", max_depth <= 1, 1);
        check("b2b_count", out_log.size(), 8 * 3);
        foreach (out_log[i]) begin
            check($sformatf("b2b_last%0d", i), out_log[i].last, (i % 3) == 2);
        end

        // Random gaps and random consumer backpressure.
        rand_ready = 1'b1;
        for (int i = 0; i < 12 * LEN; i++) begin
            repeat ($urandom_range(0, 2)) sync();
            v = ($urandom_range(0, 5) == 0) ? 16'sd32767 : WIDTH'($urandom);
            send(v);
        end
        rand_ready = 1'b0;
        sync();
        m_ready_z = 1'b1;
        drain();
        check("final_model_empty", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
